// File: rtl/dram_lsu_pkg.sv
// Shared constants and byte-lane helpers for the RV32I data-memory load/store unit.
// Optional build macro: DRAM_MISALIGN_CHK_EN (consumed by dram_lsu).
package dram_lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;

  // Access size is encoded in func3[1:0]: 00 byte, 01 half, 10 word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic ld_legal(input logic [2:0] f3);
    return (f3 == INST_LB) || (f3 == INST_LH) || (f3 == INST_LW) ||
           (f3 == INST_LBU) || (f3 == INST_LHU);
  endfunction

  function automatic logic st_legal(input logic [2:0] f3);
    return (f3 == INST_SB) || (f3 == INST_SH) || (f3 == INST_SW);
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
    return ((sz == SZ_HALF) && lane[0]) || ((sz == SZ_WORD) && (lane != 2'b00));
  endfunction

  // Force the lane to natural alignment for the access size.
  function automatic logic [1:0] align_lane(input logic [1:0] sz, input logic [1:0] lane);
    logic [1:0] r;
    r = lane;
    if (sz == SZ_HALF) r = {lane[1], 1'b0};
    else if (sz == SZ_WORD) r = 2'b00;
    return r;
  endfunction

  function automatic logic [3:0] st_strobe(input logic [1:0] sz, input logic [1:0] lane);
    logic [3:0] r;
    r = 4'(4'b0001 << lane);
    if (sz == SZ_HALF) r = lane[1] ? 4'b1100 : 4'b0011;
    else if (sz == SZ_WORD) r = 4'b1111;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] st_replicate(input logic [1:0] sz, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    r = d;
    if (sz == SZ_BYTE) r = {4{d[7:0]}};
    else if (sz == SZ_HALF) r = {2{d[15:0]}};
    return r;
  endfunction

  function automatic logic [XLEN-1:0] ld_extract(input logic [XLEN-1:0] w,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] lane);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = 8'(w >> {lane, 3'b000});
    h = 16'(w >> {lane[1], 4'b0000});
    case (f3)
      INST_LB:  r = {{24{b[7]}}, b};
      INST_LBU: r = {24'h0, b};
      INST_LH:  r = {{16{h[15]}}, h};
      INST_LHU: r = {16'h0, h};
      INST_LW:  r = w;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dram_lsu_if.sv
// Load/store request and response bundle between the pipeline and dram_lsu.
interface dram_lsu_if;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic [2:0]  ld_func3;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [2:0]  st_func3;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        err_o;

  modport master (
    output mem_ren, mem_raddr, ld_func3, mem_wen, mem_waddr, mem_wdata, st_func3,
    input  rdata_o, rvalid_o, err_o
  );

  modport slave (
    input  mem_ren, mem_raddr, ld_func3, mem_wen, mem_waddr, mem_wdata, st_func3,
    output rdata_o, rvalid_o, err_o
  );
endinterface

// File: rtl/dram_lsu_ram.sv
// dram_ram: single-clock data RAM, one synchronous read port and one byte-strobed
// write port, read-first on address collision; shaped for block-RAM inference.
module dram_ram #(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata
);

  logic [31:0] mem [DEPTH];

  // Non-blocking read and write on the same edge gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dram_lsu.sv
// Data-memory responder for the RV32I load/store path: latency-1 loads with extension,
// byte-lane stores, range/func3 faults. Define DRAM_MISALIGN_CHK_EN to fault misaligned accesses.
module dram_lsu
  import dram_lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst_n,
  dram_lsu_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [XLEN-1:0] r_off, w_off;
  logic [AW-1:0]   r_idx, w_idx;
  logic [1:0]      r_lane, w_lane;
  logic [1:0]      r_sz, w_sz;
  logic            r_mis, w_mis;
  logic            r_err, w_err;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_rep;
  logic [XLEN-1:0] ram_q;

  logic            ld_valid_q;
  logic [2:0]      ld_f3_q;
  logic [1:0]      ld_lane_q;
  logic            ld_err_q;
  logic            err_q;
  logic [XLEN-1:0] rdata_hold_q;
  logic [XLEN-1:0] ld_result;

  // Offsets are unsigned 32-bit, so addresses below ADDR_BASE land out of range.
  assign r_off  = bus.mem_raddr - ADDR_BASE;
  assign w_off  = bus.mem_waddr - ADDR_BASE;
  assign r_idx  = r_off[AW+1:2];
  assign w_idx  = w_off[AW+1:2];
  assign r_sz   = bus.ld_func3[1:0];
  assign w_sz   = bus.st_func3[1:0];
  assign r_lane = align_lane(r_sz, r_off[1:0]);
  assign w_lane = align_lane(w_sz, w_off[1:0]);

`ifdef DRAM_MISALIGN_CHK_EN
  assign r_mis = misaligned(r_sz, r_off[1:0]);
  assign w_mis = misaligned(w_sz, w_off[1:0]);
`else
  assign r_mis = 1'b0;
  assign w_mis = 1'b0;
`endif

  assign r_err = (|r_off[XLEN-1:AW+2]) || !ld_legal(bus.ld_func3) || r_mis;
  assign w_err = (|w_off[XLEN-1:AW+2]) || !st_legal(bus.st_func3) || w_mis;
  assign w_be  = st_strobe(w_sz, w_lane);
  assign w_rep = st_replicate(w_sz, bus.mem_wdata);

  dram_ram #(.DEPTH(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .re    (bus.mem_ren),
    .raddr (r_idx),
    .rdata (ram_q),
    .we    (bus.mem_wen && !w_err),
    .be    (w_be),
    .waddr (w_idx),
    .wdata (w_rep)
  );

  // Load-side bookkeeping; the RAM word itself is the read-port register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_valid_q   <= 1'b0;
      ld_f3_q      <= 3'b000;
      ld_lane_q    <= 2'b00;
      ld_err_q     <= 1'b0;
      err_q        <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      ld_valid_q <= bus.mem_ren;
      if (bus.mem_ren) begin
        ld_f3_q   <= bus.ld_func3;
        ld_lane_q <= r_lane;
        ld_err_q  <= r_err;
      end
      err_q <= (bus.mem_ren && r_err) || (bus.mem_wen && w_err);
      if (ld_valid_q) rdata_hold_q <= ld_result;
    end
  end

  assign ld_result    = ld_err_q ? '0 : ld_extract(ram_q, ld_f3_q, ld_lane_q);
  assign bus.rdata_o  = ld_valid_q ? ld_result : rdata_hold_q;
  assign bus.rvalid_o = ld_valid_q;
  assign bus.err_o    = err_q;

endmodule
